sevenseg_scan_decoder: RTL and testbench

//   Reads a multiplexed 4-digit, active-low seven-segment bus and recovers the displayed number.

---
 rtl/sevenseg_pkg.sv | 47 ++++
 rtl/sevenseg_scan_decoder_if.sv | 22 ++
 rtl/seg_pattern_decode.sv | 31 +++
 rtl/sevenseg_scan_decoder.sv | 164 ++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for seven-segment display-bus decoding.
package sevenseg_pkg;

  // Active-low cathode patterns, bit6=a .. bit0=g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // Active-low anode slot patterns
  localparam logic [3:0] AN_THOUS = 4'b0111;
  localparam logic [3:0] AN_HUND  = 4'b1011;
  localparam logic [3:0] AN_TENS  = 4'b1101;
  localparam logic [3:0] AN_ONES  = 4'b1110;

  // Frame state encoding
  typedef logic [2:0] frame_state_t;
  localparam frame_state_t WAIT_D3 = 3'd0;
  localparam frame_state_t WAIT_D2 = 3'd1;
  localparam frame_state_t WAIT_D1 = 3'd2;
  localparam frame_state_t WAIT_D0 = 3'd3;
  localparam frame_state_t CONVERT = 3'd4;

  localparam int MAX_VALUE = 8191;

  // BCD to binary using shifts and adds only; 9999 fits in 14 bits
  function automatic logic [13:0] bcd_to_bin(input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1, input logic [3:0] d0);
    logic [13:0] t3, t2, t1, t0;
    t3 = {10'd0, d3};
    t2 = {10'd0, d2};
    t1 = {10'd0, d1};
    t0 = {10'd0, d0};
    return (t3 << 10) - (t3 << 4) - (t3 << 3)
         + (t2 << 6) + (t2 << 5) + (t2 << 2)
         + (t1 << 3) + (t1 << 1)
         + t0;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Board-facing anode/cathode bus plus the recovered-value outputs.
interface sevenseg_scan_decoder_if;
  logic [3:0]  anode_select;
  logic [6:0]  LED_out;
  logic [15:0] digits;
  logic [12:0] value;
  logic        value_valid;
  logic        digit_error;
  logic        scan_lost;

  // Display driver side
  modport master (
    output anode_select, LED_out,
    input  digits, value, value_valid, digit_error, scan_lost
  );

  // Decoder side
  modport slave (
    input  anode_select, LED_out,
    output digits, value, value_valid, digit_error, scan_lost
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational cathode-pattern to BCD decoder with a validity flag.
module seg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] cathode,
  output logic       ok,
  output logic [3:0] bcd
);

  // Map each legal digit pattern to its BCD value; everything else is rejected
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    ok  = 1'b1;
    bcd = 4'd0;
    case (cathode)
      SEG_0: bcd = 4'd0;
      SEG_1: bcd = 4'd1;
      SEG_2: bcd = 4'd2;
      SEG_3: bcd = 4'd3;
      SEG_4: bcd = 4'd4;
      SEG_5: bcd = 4'd5;
      SEG_6: bcd = 4'd6;
      SEG_7: bcd = 4'd7;
      SEG_8: bcd = 4'd8;
      SEG_9: bcd = 4'd9;
      SEG_F: ok  = 1'b0;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers the number shown on a multiplexed 4-digit active-low seven-segment bus.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_BITS  = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  sevenseg_scan_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] WD_PRE_SAT = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  logic [3:0]  an_s1, an_s2, an_prev;
  logic [6:0]  led_s1, led_s2;
  logic [CNT_W-1:0] settle_cnt;
  logic        sampled;
  logic [TIMEOUT_BITS-1:0] wd_cnt;
  frame_state_t state;
  logic [3:0]  d3, d2, d1, d0;
  logic        frame_err;
  logic [15:0] digits_q;
  logic [12:0] value_q;
  logic        value_valid_q, digit_error_q;

  logic        seg_ok;
  logic [3:0]  seg_bcd;
  logic        anode_changed, settle_done, slot_valid, sample;
  logic        wd_sat, wd_enter;
  logic [13:0] sum;

  seg_pattern_decode u_decode (
    .cathode (led_s2),
    .ok      (seg_ok),
    .bcd     (seg_bcd)
  );

  assign anode_changed = (an_s2 != an_prev);
  assign settle_done   = (settle_cnt == SETTLE_LAST);
  assign slot_valid    = (an_s2 == AN_THOUS) || (an_s2 == AN_HUND) ||
                         (an_s2 == AN_TENS)  || (an_s2 == AN_ONES);
  assign sample        = settle_done && !sampled && !anode_changed && slot_valid;
  assign wd_sat        = &wd_cnt;
  assign wd_enter      = (wd_cnt == WD_PRE_SAT) && !sample;
  assign sum           = bcd_to_bin(d3, d2, d1, d0);

  // Two-stage synchroniser for the asynchronous display pins, plus a delayed anode copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    if (reset) begin
      an_s1   <= 4'b1111;
      an_s2   <= 4'b1111;
      an_prev <= 4'b1111;
      led_s1  <= 7'h7F;
      led_s2  <= 7'h7F;
    end else begin
      an_s1   <= bus.anode_select;
      an_s2   <= an_s1;
      an_prev <= an_s2;
      led_s1  <= bus.LED_out;
      led_s2  <= led_s1;
    end
  end

  // Settle counter: restart on every anode change, sample once per stable dwell
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      sampled    <= 1'b0;
    end else if (anode_changed) begin
      settle_cnt <= '0;
      sampled    <= 1'b0;
    end else begin
      if (!settle_done) settle_cnt <= settle_cnt + 1'b1;
      else              sampled    <= 1'b1;
    end
  end

  // Scan-lost watchdog: zeroed by each sample, saturates at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        wd_cnt <= '0;
    else if (sample)  wd_cnt <= '0;
    else if (!wd_sat) wd_cnt <= wd_cnt + 1'b1;
  end

  // Frame assembly: collect thousands..ones in order, tolerating repeats of the previous slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_D3;
      d3        <= 4'd0;
      d2        <= 4'd0;
      d1        <= 4'd0;
      d0        <= 4'd0;
      frame_err <= 1'b0;
    end else begin
      if (state == CONVERT) begin
        state <= WAIT_D3;
      end else if (sample) begin
        if (an_s2 == AN_THOUS) begin
          d3        <= seg_bcd;
          frame_err <= !seg_ok;
          state     <= WAIT_D2;
        end else begin
          case (state)
            WAIT_D2: begin
              if (an_s2 == AN_HUND) begin
                d2 <= seg_bcd; frame_err <= frame_err | !seg_ok; state <= WAIT_D1;
              end else state <= WAIT_D3;
            end
            WAIT_D1: begin
              if (an_s2 == AN_TENS) begin
                d1 <= seg_bcd; frame_err <= frame_err | !seg_ok; state <= WAIT_D0;
              end else if (an_s2 == AN_HUND) begin
                d2 <= seg_bcd; frame_err <= frame_err | !seg_ok;
              end else state <= WAIT_D3;
            end
            WAIT_D0: begin
              if (an_s2 == AN_ONES) begin
                d0 <= seg_bcd; frame_err <= frame_err | !seg_ok; state <= CONVERT;
              end else if (an_s2 == AN_TENS) begin
                d1 <= seg_bcd; frame_err <= frame_err | !seg_ok;
              end else state <= WAIT_D3;
            end
            default: state <= WAIT_D3;
          endcase
        end
      end
      // Losing the scan abandons any partial frame
      if (wd_enter) state <= WAIT_D3;
    end
  end

  // Conversion result: publish a good frame or flag a rejected one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q      <= 16'd0;
      value_q       <= 13'd0;
      value_valid_q <= 1'b0;
      digit_error_q <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      digit_error_q <= 1'b0;
      if (state == CONVERT) begin
        if (!frame_err && (sum <= 14'(MAX_VALUE))) begin
          digits_q      <= {d3, d2, d1, d0};
          value_q       <= sum[12:0];
          value_valid_q <= 1'b1;
        end else begin
          digit_error_q <= 1'b1;
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.digit_error = digit_error_q;
  assign bus.scan_lost   = wd_sat;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed testbench for sevenseg_scan_decoder (SETTLE_CYCLES=4, TIMEOUT_BITS=8).
module tb_sevenseg_scan_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   vv_cnt = 0;
  int   de_cnt = 0;
  int   both_cnt = 0;
  int   v0, e0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  sevenseg_scan_decoder_if bus ();

  sevenseg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.value_valid) vv_cnt++;
    if (bus.digit_error) de_cnt++;
    if (bus.value_valid && bus.digit_error) both_cnt++;
  end

  task automatic scan_digit(input logic [3:0] an, input logic [6:0] seg, input int dwell);
    bus.anode_select = an;
    bus.LED_out      = seg;
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  task automatic scan_frame(input int a, input int b, input int c, input int d);
    scan_digit(4'b0111, seg_tab[a], 16);
    scan_digit(4'b1011, seg_tab[b], 16);
    scan_digit(4'b1101, seg_tab[c], 16);
    scan_digit(4'b1110, seg_tab[d], 16);
  endtask

  task automatic test_reset();
    bus.anode_select = 4'b1111;
    bus.LED_out      = 7'h7F;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.digits !== 16'h0000) $display("FAIL reset_digits got %h exp 0000", bus.digits); else passed++;
    total++; if (bus.value !== 13'd0) $display("FAIL reset_value got %0d exp 0", bus.value); else passed++;
    total++; if (bus.value_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.value_valid); else passed++;
    total++; if (bus.digit_error !== 1'b0) $display("FAIL reset_error got %b exp 0", bus.digit_error); else passed++;
    total++; if (bus.scan_lost !== 1'b0) $display("FAIL reset_scan_lost got %b exp 0", bus.scan_lost); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    v0 = vv_cnt; e0 = de_cnt;
    scan_frame(1, 2, 3, 4);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 1) $display("FAIL f1234_pulses got %0d exp 1", vv_cnt - v0); else passed++;
    total++; if (de_cnt - e0 !== 0) $display("FAIL f1234_errors got %0d exp 0", de_cnt - e0); else passed++;
    total++; if (bus.digits !== 16'h1234) $display("FAIL f1234_digits got %h exp 1234", bus.digits); else passed++;
    total++; if (bus.value !== 13'd1234) $display("FAIL f1234_value got %0d exp 1234", bus.value); else passed++;
    v0 = vv_cnt;
    for (int i = 0; i < 3; i++) scan_frame(1, 2, 3, 4);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 3) $display("FAIL repeat_pulses got %0d exp 3", vv_cnt - v0); else passed++;
  endtask

  task automatic test_max_and_overflow();
    v0 = vv_cnt;
    scan_frame(8, 1, 9, 1);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 1) $display("FAIL max_pulses got %0d exp 1", vv_cnt - v0); else passed++;
    total++; if (bus.value !== 13'd8191) $display("FAIL max_value got %0d exp 8191", bus.value); else passed++;
    total++; if (bus.digits !== 16'h8191) $display("FAIL max_digits got %h exp 8191", bus.digits); else passed++;
    v0 = vv_cnt; e0 = de_cnt;
    scan_frame(9, 0, 0, 0);
    @(negedge clk);
    total++; if (de_cnt - e0 !== 1) $display("FAIL ovf_errors got %0d exp 1", de_cnt - e0); else passed++;
    total++; if (vv_cnt - v0 !== 0) $display("FAIL ovf_pulses got %0d exp 0", vv_cnt - v0); else passed++;
    total++; if (bus.value !== 13'd8191) $display("FAIL ovf_value_hold got %0d exp 8191", bus.value); else passed++;
  endtask

  task automatic test_bad_segment();
    v0 = vv_cnt; e0 = de_cnt;
    scan_digit(4'b0111, seg_tab[5], 16);
    scan_digit(4'b1011, seg_tab[6], 16);
    scan_digit(4'b1101, 7'b0111000, 16);
    scan_digit(4'b1110, seg_tab[7], 16);
    @(negedge clk);
    total++; if (de_cnt - e0 !== 1) $display("FAIL badseg_errors got %0d exp 1", de_cnt - e0); else passed++;
    total++; if (vv_cnt - v0 !== 0) $display("FAIL badseg_pulses got %0d exp 0", vv_cnt - v0); else passed++;
    total++; if (bus.digits !== 16'h8191) $display("FAIL badseg_digits_hold got %h exp 8191", bus.digits); else passed++;
    v0 = vv_cnt;
    scan_frame(0, 0, 4, 2);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 1) $display("FAIL f42_pulses got %0d exp 1", vv_cnt - v0); else passed++;
    total++; if (bus.value !== 13'd42) $display("FAIL f42_value got %0d exp 42", bus.value); else passed++;
  endtask

  task automatic test_order_glitch();
    v0 = vv_cnt; e0 = de_cnt;
    scan_digit(4'b0111, seg_tab[1], 16);
    scan_digit(4'b1011, seg_tab[2], 3);
    scan_digit(4'b1101, seg_tab[3], 16);
    scan_digit(4'b1110, seg_tab[4], 16);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 0) $display("FAIL glitch_pulses got %0d exp 0", vv_cnt - v0); else passed++;
    total++; if (de_cnt - e0 !== 0) $display("FAIL glitch_errors got %0d exp 0", de_cnt - e0); else passed++;
    scan_digit(4'b0111, seg_tab[1], 16);
    scan_digit(4'b1011, seg_tab[2], 16);
    scan_digit(4'b1110, seg_tab[4], 16);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 0) $display("FAIL order_pulses got %0d exp 0", vv_cnt - v0); else passed++;
    total++; if (de_cnt - e0 !== 0) $display("FAIL order_errors got %0d exp 0", de_cnt - e0); else passed++;
    scan_frame(0, 1, 0, 0);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 1) $display("FAIL f100_pulses got %0d exp 1", vv_cnt - v0); else passed++;
    total++; if (bus.value !== 13'd100) $display("FAIL f100_value got %0d exp 100", bus.value); else passed++;
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    total++; if (bus.scan_lost !== 1'b0) $display("FAIL wd_pre got %b exp 0", bus.scan_lost); else passed++;
    @(posedge clk); #1;
    scan_digit(4'b1111, 7'h7F, 300);
    @(negedge clk);
    total++; if (bus.scan_lost !== 1'b1) $display("FAIL wd_tripped got %b exp 1", bus.scan_lost); else passed++;
    @(posedge clk); #1;
    v0 = vv_cnt;
    scan_digit(4'b0111, seg_tab[4], 16);
    @(negedge clk);
    total++; if (bus.scan_lost !== 1'b0) $display("FAIL wd_cleared got %b exp 0", bus.scan_lost); else passed++;
    @(posedge clk); #1;
    scan_digit(4'b1011, seg_tab[0], 16);
    scan_digit(4'b1101, seg_tab[9], 16);
    scan_digit(4'b1110, seg_tab[6], 16);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 1) $display("FAIL f4096_pulses got %0d exp 1", vv_cnt - v0); else passed++;
    total++; if (bus.value !== 13'd4096) $display("FAIL f4096_value got %0d exp 4096", bus.value); else passed++;
  endtask

  task automatic test_reset_midframe();
    scan_digit(4'b0111, seg_tab[1], 16);
    scan_digit(4'b1011, seg_tab[2], 16);
    reset = 1'b1;
    #2;
    total++; if (bus.digits !== 16'h0000) $display("FAIL midrst_digits got %h exp 0000", bus.digits); else passed++;
    total++; if (bus.value !== 13'd0) $display("FAIL midrst_value got %0d exp 0", bus.value); else passed++;
    total++; if (bus.scan_lost !== 1'b0) $display("FAIL midrst_scan_lost got %b exp 0", bus.scan_lost); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    v0 = vv_cnt;
    scan_digit(4'b1101, seg_tab[3], 16);
    scan_digit(4'b1110, seg_tab[4], 16);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 0) $display("FAIL midrst_partial_pulses got %0d exp 0", vv_cnt - v0); else passed++;
    scan_frame(0, 0, 0, 7);
    @(negedge clk);
    total++; if (vv_cnt - v0 !== 1) $display("FAIL f7_pulses got %0d exp 1", vv_cnt - v0); else passed++;
    total++; if (bus.value !== 13'd7) $display("FAIL f7_value got %0d exp 7", bus.value); else passed++;
    total++; if (bus.digits !== 16'h0007) $display("FAIL f7_digits got %h exp 0007", bus.digits); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_max_and_overflow();
    test_bad_segment();
    test_order_glitch();
    test_watchdog();
    test_reset_midframe();
    total++; if (both_cnt !== 0) $display("FAIL valid_and_error_overlap got %0d exp 0", both_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
